vga_source_scheduler: RTL and testbench

//  Frame-synchronous selector between NUM_SRC pixel sources (test pattern, switch colour, ...) feeding
//  the VGA RGB port. Sits between the pixel generators and r/g/b_port, after the VGA timing decoder.

---
 rtl/vga_source_scheduler.sv | 164 ++++++++++++++++
 tb/tb_vga_source_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_source_scheduler.sv
// Frame-synchronous selector between NUM_SRC pixel sources driving the VGA RGB port.
// Define VGA_SRC_BORDER_EN to draw a white one-pixel border around the visible area.
module vga_source_scheduler #(
    parameter int  NUM_SRC      = 4,
    parameter int  AUTO_FRAMES  = 120,
    parameter int  BLANK_FRAMES = 1,
    parameter bit  VSYNC_POL    = 1'b0,
    parameter int  H_ACTIVE     = 640,
    parameter int  V_ACTIVE     = 480,
    localparam int SEL_W        = $clog2(NUM_SRC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  v_sync,
    input  logic                  DE,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    input  logic [NUM_SRC*12-1:0] src_rgb,
    input  logic                  btn_next,
    input  logic                  auto_en,
    output logic [SEL_W-1:0]      sel,
    output logic                  switching,
    output logic [3:0]            r_port,
    output logic [3:0]            g_port,
    output logic [3:0]            b_port
);

    typedef enum logic [1:0] {SHOW, PEND, BLANK} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   next_sel_q, next_sel_d;
    logic [9:0]         frame_cnt_q, frame_cnt_d;
    logic [1:0]         blank_cnt_q, blank_cnt_d;
    logic               switching_q, switching_d;
    logic [11:0]        rgb_q, rgb_d;
    logic               vs_q, vs_prev_q, btn_q;
    logic               frame_tick, btn_req, auto_req, req;
    logic [11:0]        src_arr [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_arr[gi] = src_rgb[12*gi +: 12];
    end

    function automatic logic [SEL_W-1:0] inc_sel(input logic [SEL_W-1:0] s);
        return (s == SEL_W'(NUM_SRC-1)) ? '0 : s + SEL_W'(1);
    endfunction

    always_comb begin
        frame_tick  = (vs_q == VSYNC_POL) && (vs_prev_q != VSYNC_POL);
        btn_req     = btn_next && !btn_q;
        auto_req    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        // The auto counter only advances while a source is settled on screen.
        if (!auto_en) begin
            frame_cnt_d = '0;
        end else if (state_q == SHOW && frame_tick) begin
            if (frame_cnt_q == 10'(AUTO_FRAMES-1)) begin
                frame_cnt_d = '0;
                auto_req    = 1'b1;
            end else begin
                frame_cnt_d = frame_cnt_q + 10'd1;
            end
        end
        req = btn_req || auto_req;
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        next_sel_d  = next_sel_q;
        blank_cnt_d = blank_cnt_q;
        switching_d = switching_q;
        case (state_q)
            SHOW: begin
                if (req) begin
                    state_d     = PEND;
                    next_sel_d  = inc_sel(sel_q);
                    switching_d = 1'b1;
                end
            end
            PEND: begin
                // A request landing on the commit tick still counts toward the target.
                if (req) begin
                    next_sel_d = inc_sel(next_sel_q);
                end
                if (frame_tick) begin
                    if (BLANK_FRAMES == 0) begin
                        sel_d       = next_sel_d;
                        state_d     = SHOW;
                        switching_d = 1'b0;
                    end else begin
                        blank_cnt_d = 2'(BLANK_FRAMES);
                        state_d     = BLANK;
                    end
                end
            end
            BLANK: begin
                if (frame_tick) begin
                    if (blank_cnt_q == 2'd1) begin
                        blank_cnt_d = '0;
                        sel_d       = next_sel_q;
                        state_d     = SHOW;
                        switching_d = 1'b0;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 2'd1;
                    end
                end
            end
            default: state_d = SHOW;
        endcase
    end

    always_comb begin
        rgb_d = 12'h000;
        if (DE && state_q != BLANK) begin
            rgb_d = src_arr[sel_q];
        end
`ifdef VGA_SRC_BORDER_EN
        if (DE && (pixel_x == 10'd0 || pixel_x == 10'(H_ACTIVE-1) ||
                   pixel_y == 10'd0 || pixel_y == 10'(V_ACTIVE-1))) begin
            rgb_d = 12'hFFF;
        end
`endif
    end

`ifndef VGA_SRC_BORDER_EN
    logic unused_border;
    assign unused_border = ^{pixel_x, pixel_y, 10'(H_ACTIVE), 10'(V_ACTIVE)};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SHOW;
            sel_q       <= '0;
            next_sel_q  <= '0;
            frame_cnt_q <= '0;
            blank_cnt_q <= '0;
            switching_q <= 1'b0;
            rgb_q       <= 12'h000;
            vs_q        <= ~VSYNC_POL;
            vs_prev_q   <= ~VSYNC_POL;
            btn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            next_sel_q  <= next_sel_d;
            frame_cnt_q <= frame_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            switching_q <= switching_d;
            rgb_q       <= rgb_d;
            vs_q        <= v_sync;
            vs_prev_q   <= vs_q;
            btn_q       <= btn_next;
        end
    end

    assign sel       = sel_q;
    assign switching = switching_q;
    assign r_port    = rgb_q[11:8];
    assign g_port    = rgb_q[7:4];
    assign b_port    = rgb_q[3:0];

endmodule

// File: tb/tb_vga_source_scheduler.sv
// Bench for vga_source_scheduler: two instances (no blanking / one blank frame) on shared stimulus.
module tb_vga_source_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        v_sync = 1'b1;
    logic        de = 1'b0;
    logic [9:0]  pixel_x = 10'd5;
    logic [9:0]  pixel_y = 10'd5;
    logic [47:0] src_rgb = {12'hABC, 12'h789, 12'h456, 12'h123};
    logic        btn_next = 1'b0;
    logic        auto_en = 1'b0;

    logic [1:0]  sel0, sel1;
    logic        sw0, sw1;
    logic [3:0]  r0, g0, b0, r1, g1, b1;

    int cyc = 0;
    int checks = 0;
    int passed = 0;

    typedef struct {
        int          cyc;
        int          id;
        int          field;
        logic [11:0] val;
        string       name;
    } exp_t;
    exp_t sb[$];

    vga_source_scheduler #(.NUM_SRC(4), .AUTO_FRAMES(3), .BLANK_FRAMES(0), .VSYNC_POL(1'b0)) dut0 (
        .clk(clk), .reset(reset), .v_sync(v_sync), .DE(de), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .src_rgb(src_rgb), .btn_next(btn_next), .auto_en(auto_en), .sel(sel0), .switching(sw0),
        .r_port(r0), .g_port(g0), .b_port(b0));

    vga_source_scheduler #(.NUM_SRC(4), .AUTO_FRAMES(3), .BLANK_FRAMES(1), .VSYNC_POL(1'b0)) dut1 (
        .clk(clk), .reset(reset), .v_sync(v_sync), .DE(de), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .src_rgb(src_rgb), .btn_next(btn_next), .auto_en(auto_en), .sel(sel1), .switching(sw1),
        .r_port(r1), .g_port(g1), .b_port(b1));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] actual(input int id, input int field);
        case ({id[0], field[1:0]})
            3'b000: return {10'd0, sel0};
            3'b001: return {11'd0, sw0};
            3'b010: return {r0, g0, b0};
            3'b100: return {10'd0, sel1};
            3'b101: return {11'd0, sw1};
            3'b110: return {r1, g1, b1};
            default: return 12'hXXX;
        endcase
    endfunction

    // Monitor: pops every expectation due in the current cycle and compares on the falling edge.
    initial forever begin
        @(negedge clk);
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [11:0] a;
            e = sb.pop_front();
            a = actual(e.id, e.field);
            checks++;
            if (e.cyc != cyc)
                $display("FAIL %s dut%0d: expectation for cycle %0d checked late at %0d", e.name, e.id, e.cyc, cyc);
            else if (a !== e.val)
                $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", e.name, e.id, a, e.val, cyc);
            else begin
                passed++;
                $display("check %s dut%0d = %h ok (cycle %0d)", e.name, e.id, a, cyc);
            end
        end
    end

    task automatic expect_val(input int id, input int field, input logic [11:0] v, input string nm);
        exp_t e;
        e.cyc = cyc; e.id = id; e.field = field; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic exp_both(input int id, input logic [1:0] s, input logic w, input string nm);
        expect_val(id, 0, {10'd0, s}, {nm, "_sel"});
        expect_val(id, 1, {11'd0, w}, {nm, "_sw"});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_tick();
        v_sync = 1'b0;
        step();
        v_sync = 1'b1;
        step();
    endtask

    task automatic press();
        btn_next = 1'b1;
        step();
        btn_next = 1'b0;
        step();
    endtask

    initial begin
        // Reset and pixel path
        repeat (3) step();
        for (int i = 0; i < 2; i++) begin
            exp_both(i, 2'd0, 1'b0, "reset");
            expect_val(i, 2, 12'h000, "reset_rgb");
        end
        reset = 1'b1;
        de = 1'b1;
        step();
        expect_val(0, 2, 12'h123, "rgb_src0");
        expect_val(1, 2, 12'h123, "rgb_src0");
        de = 1'b0;
        step();
        expect_val(0, 2, 12'h000, "rgb_de0");
        de = 1'b1;
`ifdef VGA_SRC_BORDER_EN
        pixel_x = 10'd0; pixel_y = 10'd0;
        step();
        expect_val(0, 2, 12'hFFF, "border_00");
        pixel_x = 10'd639; pixel_y = 10'd479;
        step();
        expect_val(1, 2, 12'hFFF, "border_end");
        pixel_x = 10'd5; pixel_y = 10'd5;
`endif
        step();

        // Button press: pending until the frame tick
        btn_next = 1'b1;
        step();
        exp_both(0, 2'd0, 1'b1, "press_pend");
        exp_both(1, 2'd0, 1'b1, "press_pend");
        btn_next = 1'b0;
        step();
        step();
        exp_both(0, 2'd0, 1'b1, "pend_hold");
        v_sync = 1'b0;
        step();
        exp_both(0, 2'd0, 1'b1, "tick_detect");
        v_sync = 1'b1;
        step();
        exp_both(0, 2'd1, 1'b0, "commit");
        expect_val(0, 2, 12'h123, "commit_old_rgb");
        exp_both(1, 2'd0, 1'b1, "enter_blank");
        step();
        expect_val(0, 2, 12'h456, "rgb_src1");
        expect_val(1, 2, 12'h000, "blank_rgb");

        // Press during dut1 BLANK is ignored there, taken by dut0
        btn_next = 1'b1;
        step();
        exp_both(0, 2'd1, 1'b1, "press2");
        exp_both(1, 2'd0, 1'b1, "blank_ignore");
        btn_next = 1'b0;
        step();
        frame_tick();
        exp_both(0, 2'd2, 1'b0, "commit2");
        exp_both(1, 2'd1, 1'b0, "blank_commit");
        step();
        expect_val(0, 2, 12'h789, "rgb_src2");
        expect_val(1, 2, 12'h456, "rgb_src1_after_blank");

        // Two presses in PEND from sel=3 wrap to 1
        press();
        frame_tick();
        exp_both(0, 2'd3, 1'b0, "to_sel3");
        exp_both(1, 2'd1, 1'b1, "blank_again");
        press();
        press();
        frame_tick();
        exp_both(0, 2'd1, 1'b0, "two_press_wrap");
        exp_both(1, 2'd2, 1'b0, "blank_commit2");

        // Held button: one change only
        btn_next = 1'b1;
        step();
        for (int f = 0; f < 5; f++) frame_tick();
        exp_both(0, 2'd2, 1'b0, "held_once");
        exp_both(1, 2'd3, 1'b0, "held_once");
        btn_next = 1'b0;
        step();

        // Asynchronous reset during BLANK
        press();
        frame_tick();
        step();
        expect_val(0, 2, 12'hABC, "rgb_src3");
        exp_both(1, 2'd3, 1'b1, "pre_reset_blank");
        step();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_both(i, 2'd0, 1'b0, "async_reset");
            expect_val(i, 2, 12'h000, "async_reset_rgb");
        end
        step();
        step();
        reset = 1'b1;
        step();

        // Auto-cycle: dut0 changes every 4 ticks, dut1 every 5
        auto_en = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            frame_tick();
            exp_both(0, 2'((k / 4) % 4), (k % 4) == 3, $sformatf("auto_k%0d", k));
            exp_both(1, 2'((k / 5) % 4), ((k % 5) == 3) || ((k % 5) == 4), $sformatf("auto_k%0d", k));
        end
        auto_en = 1'b0;
        step();
        step();

        checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        else
            passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
